// File: rtl/composite_sync_gen.sv
// -----------------------------------------------------------------------------
// composite_sync_gen
//
// NTSC-style 262-line progressive (240p) composite timing generator. All
// timing is counted in cycles of the 119.0476 MHz PLL clock. A horizontal
// counter (hcnt) and a line counter (vcnt) are decoded into sync, blank,
// colour-burst and active-picture windows. A pixel phase counter and a column
// counter produce a pixel strobe and coordinates for a 256x240 video source.
//
// Every output is a register loaded from the decode of the current
// (hcnt, vcnt). An output therefore describes the counter position of the
// previous clock, which is a latency of exactly one clock.
//
// Ports
//   clk          in   PLL output clock
//   rst_n        in   asynchronous active-low reset (released synchronously)
//   sync_n       out  0 = sync tip level
//   blank        out  1 = blanking level (outside the active region)
//   burst        out  1 = colour-burst window
//   active       out  1 = active picture region
//   pix_ce       out  one-clock strobe at the start of each active pixel
//   pix_x [7:0]  out  pixel column, valid with pix_ce
//   pix_y [7:0]  out  pixel row, valid while active
//   line_start   out  one-clock pulse for hcnt == 0
//   frame_start  out  one-clock pulse for hcnt == 0 and vcnt == 0
// -----------------------------------------------------------------------------
module composite_sync_gen #(
  parameter int unsigned H_TOTAL     = 7566,  // clocks per line
  parameter int unsigned H_SYNC      = 560,   // normal hsync low width
  parameter int unsigned EQ_W        = 274,   // equalizing pulse low width
  parameter int unsigned BURST_START = 631,   // first burst clock in line
  parameter int unsigned BURST_LEN   = 298,   // burst window length
  parameter int unsigned H_ACT_START = 1298,  // first active clock in line
  parameter int unsigned PIX_DIV     = 24,    // clocks per pixel
  parameter int unsigned PIX_W       = 256,   // active pixels per line
  parameter int unsigned V_TOTAL     = 262,   // lines per frame
  parameter int unsigned V_ACT_START = 22,    // first active line
  parameter int unsigned PIX_H       = 240    // active lines
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       sync_n,
  output logic       blank,
  output logic       burst,
  output logic       active,
  output logic       pix_ce,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_HALF = H_TOTAL / 2;

  // One spare value of headroom so the exclusive end bounds of the active
  // windows (which may equal H_TOTAL / V_TOTAL) always fit.
  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);
  localparam int unsigned PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned XW = $clog2(PIX_W + 1);

  // Horizontal landmarks, sized to the counter so comparisons are exact-width.
  localparam logic [HW-1:0] H_LAST        = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_HALF_C      = HW'(H_HALF);
  localparam logic [HW-1:0] H_SYNC_END    = HW'(H_SYNC);
  localparam logic [HW-1:0] H_EQ_END      = HW'(EQ_W);
  localparam logic [HW-1:0] H_HALF_EQ_END = HW'(H_HALF + EQ_W);
  localparam logic [HW-1:0] H_VS_END_A    = HW'(H_HALF - H_SYNC);
  localparam logic [HW-1:0] H_VS_END_B    = HW'(H_TOTAL - H_SYNC);
  localparam logic [HW-1:0] H_BURST_BEG   = HW'(BURST_START);
  localparam logic [HW-1:0] H_BURST_END   = HW'(BURST_START + BURST_LEN);
  localparam logic [HW-1:0] H_ACT_BEG     = HW'(H_ACT_START);
  localparam logic [HW-1:0] H_ACT_END     = HW'(H_ACT_START + PIX_W * PIX_DIV);

  // Vertical landmarks. Lines 0-2 and 6-8 equalize, 3-5 carry serrated vsync.
  localparam logic [VW-1:0] V_LAST        = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VS_BEG      = VW'(3);
  localparam logic [VW-1:0] V_VS_END      = VW'(6);
  localparam logic [VW-1:0] V_VBLANK_END  = VW'(9);
  localparam logic [VW-1:0] V_ACT_BEG     = VW'(V_ACT_START);
  localparam logic [VW-1:0] V_ACT_END     = VW'(V_ACT_START + PIX_H);

  localparam logic [PW-1:0] P_LAST        = PW'(PIX_DIV - 1);

  typedef enum logic [1:0] {
    LINE_EQ,      // two short equalizing pulses per line
    LINE_VSYNC,   // broad serrated vertical sync pulses
    LINE_NORMAL   // one hsync pulse
  } line_kind_e;

  // Counter state.
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [XW-1:0] xcnt_q, xcnt_d;

  // Output registers.
  logic       sync_n_q, sync_n_d;
  logic       blank_q, blank_d;
  logic       burst_q, burst_d;
  logic       active_q, active_d;
  logic       pix_ce_q, pix_ce_d;
  logic [7:0] pix_x_q, pix_x_d;
  logic [7:0] pix_y_q, pix_y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  // Decode intermediates.
  line_kind_e    line_kind;
  logic          sync_low;
  logic          act_h;
  logic          act_v;
  logic          act;
  logic [PW-1:0] phase_cur;
  logic [XW-1:0] x_cur;

  // ---------------------------------------------------------------------------
  // Line / frame counters: seamless wrap, no dead clock.
  // ---------------------------------------------------------------------------
  always_comb begin : counter_next
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Window decode from the current counter position.
  // ---------------------------------------------------------------------------
  always_comb begin : decode
    line_kind = LINE_NORMAL;
    if (vcnt_q < V_VS_BEG) begin
      line_kind = LINE_EQ;
    end else if (vcnt_q < V_VS_END) begin
      line_kind = LINE_VSYNC;
    end else if (vcnt_q < V_VBLANK_END) begin
      line_kind = LINE_EQ;
    end

    unique case (line_kind)
      LINE_EQ:    sync_low = (hcnt_q < H_EQ_END) ||
                             ((hcnt_q >= H_HALF_C) && (hcnt_q < H_HALF_EQ_END));
      LINE_VSYNC: sync_low = (hcnt_q < H_VS_END_A) ||
                             ((hcnt_q >= H_HALF_C) && (hcnt_q < H_VS_END_B));
      default:    sync_low = (hcnt_q < H_SYNC_END);
    endcase

    act_h = (hcnt_q >= H_ACT_BEG) && (hcnt_q < H_ACT_END);
    act_v = (vcnt_q >= V_ACT_BEG) && (vcnt_q < V_ACT_END);
    act   = act_h && act_v;

    // Phase and column are re-aligned at the first active clock of every
    // line, so any drift outside the active window never reaches the outputs.
    phase_cur = (hcnt_q == H_ACT_BEG) ? '0 : phase_q;
    x_cur     = (hcnt_q == H_ACT_BEG) ? '0 : xcnt_q;

    phase_d = (phase_cur == P_LAST) ? '0 : phase_cur + 1'b1;
    // The column advances on the last clock of a pixel so pix_x equals
    // (hcnt - H_ACT_START) / PIX_DIV on every clock of that pixel.
    xcnt_d  = (act_h && (phase_cur == P_LAST)) ? x_cur + 1'b1 : x_cur;

    sync_n_d      = ~sync_low;
    burst_d       = (vcnt_q >= V_VBLANK_END) &&
                    (hcnt_q >= H_BURST_BEG) && (hcnt_q < H_BURST_END);
    active_d      = act;
    blank_d       = ~act;
    pix_ce_d      = act && (phase_cur == '0);
    pix_x_d       = act ? 8'(x_cur) : 8'd0;
    pix_y_d       = act_v ? 8'(vcnt_q - V_ACT_BEG) : 8'd0;
    line_start_d  = (hcnt_q == '0);
    frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      phase_q       <= '0;
      xcnt_q        <= '0;
      sync_n_q      <= 1'b1;
      blank_q       <= 1'b1;
      burst_q       <= 1'b0;
      active_q      <= 1'b0;
      pix_ce_q      <= 1'b0;
      pix_x_q       <= 8'd0;
      pix_y_q       <= 8'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      phase_q       <= phase_d;
      xcnt_q        <= xcnt_d;
      sync_n_q      <= sync_n_d;
      blank_q       <= blank_d;
      burst_q       <= burst_d;
      active_q      <= active_d;
      pix_ce_q      <= pix_ce_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sync_n      = sync_n_q;
  assign blank       = blank_q;
  assign burst       = burst_q;
  assign active      = active_q;
  assign pix_ce      = pix_ce_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_composite_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_composite_sync_gen
//
// Two instances share clock and reset:
//   u_dut_d  full NTSC parameters; checked on reset, release and lines 0-4
//            (equalizing and serrated vsync widths, line period).
//   u_dut_s  scaled parameters so a whole frame is 3600 clocks; checked on
//            every window, pixel stepping, frame totals and mid-frame reset.
// Scaled set: H_TOTAL 120, H_SYNC 10, EQ_W 5, BURST 12+6, H_ACT_START 24,
// PIX_DIV 3, PIX_W 30, V_TOTAL 30, V_ACT_START 10, PIX_H 20 (H_HALF 60).
// Each line is measured from the sample carrying line_start; sample index i
// of a line corresponds to hcnt == i.
// -----------------------------------------------------------------------------
module tb_composite_sync_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       d_sync_n, d_blank, d_burst, d_active, d_pix_ce, d_line_start, d_frame_start;
  logic [7:0] d_pix_x, d_pix_y;
  logic       s_sync_n, s_blank, s_burst, s_active, s_pix_ce, s_line_start, s_frame_start;
  logic [7:0] s_pix_x, s_pix_y;

  composite_sync_gen u_dut_d (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_n      (d_sync_n),
    .blank       (d_blank),
    .burst       (d_burst),
    .active      (d_active),
    .pix_ce      (d_pix_ce),
    .pix_x       (d_pix_x),
    .pix_y       (d_pix_y),
    .line_start  (d_line_start),
    .frame_start (d_frame_start)
  );

  composite_sync_gen #(
    .H_TOTAL     (120),
    .H_SYNC      (10),
    .EQ_W        (5),
    .BURST_START (12),
    .BURST_LEN   (6),
    .H_ACT_START (24),
    .PIX_DIV     (3),
    .PIX_W       (30),
    .V_TOTAL     (30),
    .V_ACT_START (10),
    .PIX_H       (20)
  ) u_dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .sync_n      (s_sync_n),
    .blank       (s_blank),
    .burst       (s_burst),
    .active      (s_active),
    .pix_ce      (s_pix_ce),
    .pix_x       (s_pix_x),
    .pix_y       (s_pix_y),
    .line_start  (s_line_start),
    .frame_start (s_frame_start)
  );

  // {sync_n, blank, burst, active, pix_ce, pix_x, pix_y, line_start, frame_start}
  localparam logic [22:0] RST_BUS = 23'h600000;
  logic [22:0] d_bus, s_bus;
  assign d_bus = {d_sync_n, d_blank, d_burst, d_active, d_pix_ce, d_pix_x, d_pix_y,
                  d_line_start, d_frame_start};
  assign s_bus = {s_sync_n, s_blank, s_burst, s_active, s_pix_ce, s_pix_x, s_pix_y,
                  s_line_start, s_frame_start};

  // Monitor selects which instance the line measurement looks at.
  logic       sel;
  logic       m_sync, m_blank, m_burst, m_active, m_pix_ce, m_line_start, m_frame_start;
  logic [7:0] m_pix_x, m_pix_y;
  assign m_sync        = sel ? s_sync_n      : d_sync_n;
  assign m_blank       = sel ? s_blank       : d_blank;
  assign m_burst       = sel ? s_burst       : d_burst;
  assign m_active      = sel ? s_active      : d_active;
  assign m_pix_ce      = sel ? s_pix_ce      : d_pix_ce;
  assign m_pix_x       = sel ? s_pix_x       : d_pix_x;
  assign m_pix_y       = sel ? s_pix_y       : d_pix_y;
  assign m_line_start  = sel ? s_line_start  : d_line_start;
  assign m_frame_start = sel ? s_frame_start : d_frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Per-line measurement results.
  int len, nrun, run_lvl0;
  int run_len [8];
  int burst_first, burst_cnt, act_first, act_cnt;
  int ce_first, ce_cnt, gap_min, gap_max, x_err, x_last, x_bad;
  int y_at_act, y_max, blank_bad, fs0, fs_mid;

  // Entry: current negedge sample carries line_start. Exit: at the sample of
  // the next line_start, or after 'bound' samples if it never arrives.
  task automatic measure_line(input int bound);
    logic prev_sync;
    int   last_ce;
    len = 0; nrun = 0; run_lvl0 = 0;
    for (int i = 0; i < 8; i++) run_len[i] = 0;
    burst_first = -1; burst_cnt = 0; act_first = -1; act_cnt = 0;
    ce_first = -1; ce_cnt = 0; gap_min = 1000000; gap_max = 0;
    x_err = 0; x_last = 0; x_bad = 0; y_at_act = 0; y_max = 0; blank_bad = 0;
    fs0 = int'(m_frame_start); fs_mid = 0;
    prev_sync = m_sync; last_ce = 0;
    do begin
      if (len == 0) begin
        run_lvl0 = int'(m_sync); nrun = 1; run_len[0] = 1;
      end else if (m_sync == prev_sync) begin
        if (nrun <= 8) run_len[nrun-1]++;
      end else begin
        nrun++;
        if (nrun <= 8) run_len[nrun-1] = 1;
      end
      prev_sync = m_sync;
      if (m_burst) begin
        if (burst_cnt == 0) burst_first = len;
        burst_cnt++;
      end
      if (m_active) begin
        if (act_cnt == 0) begin
          act_first = len;
          y_at_act  = int'(m_pix_y);
        end
        act_cnt++;
      end else if (m_pix_x != 8'd0) begin
        x_bad++;
      end
      if (m_blank == m_active) blank_bad++;
      if (int'(m_pix_y) > y_max) y_max = int'(m_pix_y);
      if (m_pix_ce) begin
        if (ce_cnt == 0) begin
          ce_first = len;
        end else begin
          if (len - last_ce < gap_min) gap_min = len - last_ce;
          if (len - last_ce > gap_max) gap_max = len - last_ce;
        end
        if (m_pix_x != ce_cnt[7:0]) x_err++;
        x_last  = int'(m_pix_x);
        last_ce = len;
        ce_cnt++;
      end
      if (len > 0 && m_frame_start) fs_mid++;
      @(negedge clk);
      len++;
    end while (!m_line_start && len < bound);
  endtask

  task automatic check_runs(input string tag, input int n,
                            input int r0, input int r1, input int r2, input int r3);
    check({tag, "_lvl0"}, run_lvl0, 0);
    check({tag, "_nrun"}, nrun, n);
    check({tag, "_run0"}, run_len[0], r0);
    check({tag, "_run1"}, run_len[1], r1);
    check({tag, "_run2"}, run_len[2], r2);
    check({tag, "_run3"}, run_len[3], r3);
  endtask

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n, tot_len, tot_ce, fs_cnt, y_bad;
    sel   = 1'b0;
    rst_n = 1'b0;

    // --- Reset and release -------------------------------------------------
    repeat (10) @(negedge clk);
    check("rst_d_bus", d_bus, RST_BUS);
    check("rst_s_bus", s_bus, RST_BUS);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_d_ls", d_line_start, 1);
    check("rel_d_fs", d_frame_start, 1);
    check("rel_d_sync", d_sync_n, 0);
    check("rel_s_ls", s_line_start, 1);
    check("rel_s_fs", s_frame_start, 1);

    // --- Full-size instance: lines 0..4 -----------------------------------
    sel = 1'b0;
    measure_line(7600);                               // line 0, equalizing
    check("d_l0_len", len, 7566);
    check("d_l0_fs0", fs0, 1);
    check("d_l0_fsmid", fs_mid, 0);
    check_runs("d_l0", 4, 274, 3509, 274, 3509);
    check("d_l0_burst", burst_cnt, 0);
    measure_line(7600);                               // line 1
    check("d_l1_len", len, 7566);
    check("d_l1_fs0", fs0, 0);
    measure_line(7600);                               // line 2
    measure_line(7600);                               // line 3, vsync
    check_runs("d_l3", 4, 3223, 560, 3223, 560);
    measure_line(7600);                               // line 4, vsync
    check("d_l4_len", len, 7566);
    check_runs("d_l4", 4, 3223, 560, 3223, 560);
    check("d_l4_burst", burst_cnt, 0);
    check("d_l4_act", act_cnt, 0);

    // --- Scaled instance: one whole frame ---------------------------------
    sel = 1'b1;
    n = 0;
    while (!m_frame_start && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("s_fs_found", m_frame_start, 1);
    tot_len = 0; tot_ce = 0; fs_cnt = 0; y_bad = 0;
    for (int l = 0; l < 30; l++) begin
      measure_line(130);
      tot_len += len;
      tot_ce  += ce_cnt;
      fs_cnt  += fs0 + fs_mid;
      if (l < 10 && y_max != 0) y_bad++;
      if (l == 0) begin
        check_runs("s_l0", 4, 5, 55, 5, 55);
        check("s_l0_burst", burst_cnt, 0);
      end
      if (l == 4) begin
        check_runs("s_l4", 4, 50, 10, 50, 10);
        check("s_l4_burst", burst_cnt, 0);
      end
      if (l == 7) begin
        check_runs("s_l7", 4, 5, 55, 5, 55);
      end
      if (l == 8) begin
        check("s_l8_burst", burst_cnt, 0);
      end
      if (l == 9) begin
        check_runs("s_l9", 2, 10, 110, 0, 0);
        check("s_l9_burst_first", burst_first, 12);
        check("s_l9_burst_cnt", burst_cnt, 6);
        check("s_l9_act", act_cnt, 0);
        check("s_l9_ce", ce_cnt, 0);
      end
      if (l == 10) begin
        check("s_l10_act_first", act_first, 24);
        check("s_l10_act_cnt", act_cnt, 90);
        check("s_l10_ce_first", ce_first, 24);
        check("s_l10_ce_cnt", ce_cnt, 30);
        check("s_l10_gap_min", gap_min, 3);
        check("s_l10_gap_max", gap_max, 3);
        check("s_l10_x_seq", x_err, 0);
        check("s_l10_x_last", x_last, 29);
        check("s_l10_x_idle", x_bad, 0);
        check("s_l10_y", y_at_act, 0);
        check("s_l10_blank", blank_bad, 0);
        check("s_l10_burst_first", burst_first, 12);
      end
      if (l == 29) begin
        check("s_l29_y", y_at_act, 19);
        check("s_l29_ce_cnt", ce_cnt, 30);
        check("s_l29_act_cnt", act_cnt, 90);
        check("s_l29_len", len, 120);
      end
    end
    check("s_frame_len", tot_len, 3600);
    check("s_frame_ce", tot_ce, 600);
    check("s_frame_fs_cnt", fs_cnt, 1);
    check("s_frame_y_idle", y_bad, 0);
    check("s_wrap_fs", m_frame_start, 1);

    // --- Mid-frame reset at line 15, hcnt 50 -------------------------------
    repeat (15 * 120 + 50) @(negedge clk);
    check("s_mid_active", s_active, 1);
    check("s_mid_pix_x", s_pix_x, 8);
    check("s_mid_pix_y", s_pix_y, 5);
    check("s_mid_pix_ce", s_pix_ce, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_d_bus", d_bus, RST_BUS);
    check("mid_rst_s_bus", s_bus, RST_BUS);
    repeat (3) @(negedge clk);
    check("mid_hold_s_bus", s_bus, RST_BUS);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_s_fs", s_frame_start, 1);
    check("mid_rel_s_ls", s_line_start, 1);
    check("mid_rel_d_fs", d_frame_start, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_frame_start && n < 4000);
    check("mid_s_frame_period", n, 3600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
